// File: rtl/experimento_3_pkg.sv
// experimento_3_pkg
//   Shared constants and helpers for the countdown timer.
//   SEG_*       : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   bin6_to_bcd : 6-bit binary (0..63) -> {tens[3:0], units[3:0]}
package experimento_3_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble over 6 input bits. Scratch layout: [13:10] tens,
    // [9:6] units, [5:0] binary still to be shifted in. The add-3 correction
    // runs before each shift so a digit >= 5 carries correctly after doubling.
    function automatic logic [7:0] bin6_to_bcd(input logic [5:0] bin);
        logic [13:0] sh;
        sh = {8'b0, bin};
        for (int i = 0; i < 6; i++) begin
            if (sh[9:6] >= 4'd5)
                sh[9:6] = sh[9:6] + 4'd3;
            if (sh[13:10] >= 4'd5)
                sh[13:10] = sh[13:10] + 4'd3;
            sh = sh << 1;
        end
        return sh[13:6];
    endfunction

endpackage

// File: rtl/experimento_3_if.sv
// experimento_3_if
//   Output bundle of the countdown timer.
//   count    : N-bit current counter value
//   done     : high while count == 0
//   display1 : tens digit segments, active-low {g,f,e,d,c,b,a}
//   display2 : units digit segments, same encoding
//   master = timer side (drives), slave = consumer side (observes).
interface experimento_3_if #(
    parameter int N = 4
);
    logic [N-1:0] count;
    logic         done;
    logic [6:0]   display1;
    logic [6:0]   display2;

    modport master (output count, output done, output display1, output display2);
    modport slave  (input  count, input  done, input  display1, input  display2);
endinterface

// File: rtl/experimento_3_seg7_decoder.sv
// seg7_decoder
//   Decimal digit to active-low 7-segment pattern.
//   digit_i : 4-bit digit value; 10..15 decode to all segments off
//   seg_o   : {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decoder
    import experimento_3_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/experimento_3.sv
// experimento_3
//   N-bit countdown timer with two-digit decimal 7-segment readout.
//   Loads all-ones on reset, decrements once every DIV clocks, holds at zero.
//   clk   : rising-edge system clock
//   reset : asynchronous, active-low; reloads 2^N-1 and clears the prescaler
//   bus   : master modport carrying count, done, display1 (tens), display2 (units)
module experimento_3
    import experimento_3_pkg::*;
#(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    experimento_3_if.master  bus
);

    // Prescaler needs at least one bit even when DIV=1 (it then stays at 0
    // and every edge is a tick).
    localparam int          PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  count_q, count_d;
    logic          tick;

    logic [5:0]    count6;
    logic [7:0]    bcd;

    // Tick on the edge where the prescaler wraps, so the first decrement
    // lands on the DIV-th edge after reset release.
    assign tick    = (presc_q == PRESC_MAX);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        count_d = count_q;
        if (tick && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= '1;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    // Widen to 6 bits so the same converter serves every legal N.
    assign count6 = 6'(count_q);
    assign bcd    = bin6_to_bcd(count6);

    seg7_decoder u_tens (
        .digit_i (bcd[7:4]),
        .seg_o   (bus.display1)
    );

    seg7_decoder u_units (
        .digit_i (bcd[3:0]),
        .seg_o   (bus.display2)
    );

    assign bus.count = count_q;
    assign bus.done  = (count_q == '0);

endmodule

// File: tb/tb_experimento_3.sv
module tb_experimento_3;

    logic clk;
    logic rst2, rst4, rst6, rst43;

    experimento_3_if #(.N(2)) b2  ();
    experimento_3_if #(.N(4)) b4  ();
    experimento_3_if #(.N(6)) b6  ();
    experimento_3_if #(.N(4)) b43 ();

    experimento_3 #(.N(2), .DIV(1)) u2  (.clk(clk), .reset(rst2),  .bus(b2));
    experimento_3 #(.N(4), .DIV(1)) u4  (.clk(clk), .reset(rst4),  .bus(b4));
    experimento_3 #(.N(6), .DIV(1)) u6  (.clk(clk), .reset(rst6),  .bus(b6));
    experimento_3 #(.N(4), .DIV(3)) u43 (.clk(clk), .reset(rst43), .bus(b43));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned cnt;
        logic        dn;
        logic [6:0]  d1;
        logic [6:0]  d2;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    end

    // Expected outputs derived from the bench's own count model.
    task automatic push_exp(input string tag, input int unsigned c);
        exp_t e;
        e.tag = tag;
        e.cnt = c;
        e.dn  = (c == 0);
        e.d1  = seg_tab[c / 10];
        e.d2  = seg_tab[c % 10];
        q.push_back(e);
    endtask

    task automatic check(input int unsigned cnt, input logic dn,
                         input logic [6:0] d1, input logic [6:0] d2);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: got output with no expectation");
            return;
        end
        e = q.pop_front();
        assert (cnt === e.cnt) else begin
            miscompares++;
            $error("FAIL %s count: got %0d expected %0d", e.tag, cnt, e.cnt);
        end
        vectors++;
        assert (dn === e.dn) else begin
            miscompares++;
            $error("FAIL %s done: got %b expected %b (count %0d)", e.tag, dn, e.dn, e.cnt);
        end
        vectors++;
        assert (d1 === e.d1) else begin
            miscompares++;
            $error("FAIL %s display1: got %b expected %b (count %0d)", e.tag, d1, e.d1, e.cnt);
        end
        vectors++;
        assert (d2 === e.d2) else begin
            miscompares++;
            $error("FAIL %s display2: got %b expected %b (count %0d)", e.tag, d2, e.d2, e.cnt);
        end
    endtask

    int unsigned m2, m4, m6, m43;
    int          p43;

    initial begin
        rst2 = 1'b0; rst4 = 1'b0; rst6 = 1'b0; rst43 = 1'b0;
        m2 = 3; m4 = 15; m6 = 63; m43 = 15; p43 = 0;

        // Reset values for every configuration
        @(negedge clk);
        @(negedge clk);
        push_exp("n2_reset", m2);   check(32'(b2.count),  b2.done,  b2.display1,  b2.display2);
        push_exp("n4_reset", m4);   check(32'(b4.count),  b4.done,  b4.display1,  b4.display2);
        push_exp("n6_reset", m6);   check(32'(b6.count),  b6.done,  b6.display1,  b6.display2);
        push_exp("n4d3_reset", m43); check(32'(b43.count), b43.done, b43.display1, b43.display2);

        // N=2: 3,2,1,0 then hold
        rst2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m2 = (m2 > 0) ? m2 - 1 : 0;
            push_exp("n2_run", m2);
            check(32'(b2.count), b2.done, b2.display1, b2.display2);
        end

        // N=4 DIV=1: 15..0 then 5 edges of hold at 0
        rst4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            m4 = (m4 > 0) ? m4 - 1 : 0;
            push_exp("n4_run", m4);
            check(32'(b4.count), b4.done, b4.display1, b4.display2);
        end

        // N=4: async reset mid-cycle at count 7
        rst4 = 1'b0; m4 = 15;
        @(negedge clk);
        rst4 = 1'b1;
        while (m4 != 7) begin
            @(negedge clk);
            m4 = m4 - 1;
            push_exp("n4_to7", m4);
            check(32'(b4.count), b4.done, b4.display1, b4.display2);
        end
        #2 rst4 = 1'b0;
        m4 = 15;
        #1;
        push_exp("n4_async_reload", m4);
        check(32'(b4.count), b4.done, b4.display1, b4.display2);
        @(negedge clk);
        push_exp("n4_held_in_reset", m4);
        check(32'(b4.count), b4.done, b4.display1, b4.display2);
        rst4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m4 = m4 - 1;
            push_exp("n4_resume", m4);
            check(32'(b4.count), b4.done, b4.display1, b4.display2);
        end

        // N=6: full sweep 63..0 with display check, then hold
        rst6 = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            m6 = (m6 > 0) ? m6 - 1 : 0;
            push_exp("n6_sweep", m6);
            check(32'(b6.count), b6.done, b6.display1, b6.display2);
        end

        // N=4 DIV=3: steps on every 3rd edge after release
        rst43 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (p43 == 2) begin
                p43 = 0;
                m43 = (m43 > 0) ? m43 - 1 : 0;
            end else begin
                p43 = p43 + 1;
            end
            push_exp("n4d3_run", m43);
            check(32'(b43.count), b43.done, b43.display1, b43.display2);
        end

        vectors++;
        assert (q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_leftover: got %0d pending expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
